// File: rtl/data_write_buffer_pkg.sv
// Shared types for the data-cache write-back buffer.
// Provides the word/line types used on the cache and arbiter data ports,
// the buffer FSM state encoding, the line tag width and a pointer-width helper.
package data_write_buffer_pkg;

  localparam int WORD_W              = 32;
  localparam int LINE_W              = 256;
  localparam int DEFAULT_OFFSET_BITS = 5;
  // Tag width for the default 32-byte line: address[31:5].
  localparam int LINE_TAG_W          = WORD_W - DEFAULT_OFFSET_BITS;

  typedef logic [WORD_W-1:0] rv32i_word;
  typedef logic [LINE_W-1:0] rv32i_line;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FWD_READ = 2'd1,
    DRAIN    = 2'd2,
    WAIT     = 2'd3
  } wb_state_t;

  // A single-entry buffer still needs a 1-bit pointer to stay a legal vector.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_write_buffer_if.sv
// Line-granular memory port (address, read/write strobes, 256-bit data,
// one-cycle resp). The master drives the request, the slave answers it.
//   master: address, read, write, wdata out; rdata, resp in
//   slave : address, read, write, wdata in;  rdata, resp out
interface data_write_buffer_if;
  import data_write_buffer_pkg::*;

  rv32i_word address;
  logic      read;
  logic      write;
  rv32i_line wdata;
  rv32i_line rdata;
  logic      resp;

  modport master (output address, read, write, wdata, input rdata, resp);
  modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/data_write_buffer_entry_fifo.sv
// Line-entry FIFO of the write-back buffer.
// Holds DEPTH tagged lines with head/tail/count, and performs the parallel
// tag match against lookup_tag. The youngest valid match is reported.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   lookup_tag          tag of the current cache request (also the push tag)
//   wr_data             line written on push or overwrite
//   push_en             append entry at tail
//   ovr_en, ovr_idx     overwrite the data of an existing entry (coalesce)
//   pop_en              retire the head entry
//   hit, hit_idx        youngest valid entry matching lookup_tag
//   hit_is_head         that match is the head entry
//   hit_data            data of the matching entry
//   head_tag, head_data head entry contents for the drain
//   full, empty         occupancy flags
module wb_entry_fifo
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = LINE_TAG_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [TAG_W-1:0]             lookup_tag,
  input  rv32i_line                    wr_data,
  input  logic                         push_en,
  input  logic                         ovr_en,
  input  logic [ptr_width(DEPTH)-1:0]  ovr_idx,
  input  logic                         pop_en,
  output logic                         hit,
  output logic [ptr_width(DEPTH)-1:0]  hit_idx,
  output logic                         hit_is_head,
  output rv32i_line                    hit_data,
  output logic [TAG_W-1:0]             head_tag,
  output rv32i_line                    head_data,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [TAG_W-1:0] tag_mem  [DEPTH];
  rv32i_line        data_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  ptr_t             head_reg;
  ptr_t             tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] match;
  ptr_t             scan_idx;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (tag_mem[gi] == lookup_tag);
    end
  endgenerate

  // Walk from oldest (head) to youngest; the last match seen wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = head_reg;
    scan_idx = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = ptr_t'(int'(head_reg) + k);
      if (match[scan_idx]) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign hit_is_head = (hit_idx == head_reg);
  assign hit_data    = data_mem[hit_idx];
  assign head_data   = data_mem[head_reg];
  assign head_tag    = tag_mem[head_reg];
  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (push_en) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= ptr_inc(tail_reg);
      end
      if (pop_en) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= ptr_inc(head_reg);
      end
      count_reg <= count_reg + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // Payload needs no reset: valid_reg gates every use of it.
  always_ff @(posedge clk) begin
    if (push_en) begin
      tag_mem[tail_reg]  <= lookup_tag;
      data_mem[tail_reg] <= wr_data;
    end else if (ovr_en) begin
      data_mem[ovr_idx]  <= wr_data;
    end
  end

endmodule

// File: rtl/data_write_buffer.sv
// Write-back buffer between the data cache memory port and the arbiter
// data port. Evicted lines are parked in a small FIFO so that the miss read
// that follows reaches memory first; reads hitting a parked line are served
// from the buffer; parked lines drain whenever no cache read is waiting.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   cache         slave side facing the data cache
//   arb           master side facing the arbiter data port
//   buf_empty     no parked lines
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int OFFSET_BITS = DEFAULT_OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  data_write_buffer_if.slave     cache,
  data_write_buffer_if.master    arb,
  output logic                   buf_empty
);

  localparam int TAG_W = WORD_W - OFFSET_BITS;
  localparam int PTR_W = ptr_width(DEPTH);

  wb_state_t        state_reg, state_next;
  logic             resp_reg, resp_next;
  rv32i_line        rdata_reg, rdata_next;
  logic             push_en, ovr_en, pop_en;
  logic             hit, hit_is_head, full;
  logic [PTR_W-1:0] hit_idx;
  rv32i_line        hit_data, head_data;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W-1:0] req_tag;
  logic [OFFSET_BITS-1:0] unused_offset;

  assign req_tag       = cache.address[WORD_W-1:OFFSET_BITS];
  assign unused_offset = cache.address[OFFSET_BITS-1:0];

  wb_entry_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .lookup_tag  (req_tag),
    .wr_data     (cache.wdata),
    .push_en     (push_en),
    .ovr_en      (ovr_en),
    .ovr_idx     (hit_idx),
    .pop_en      (pop_en),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_is_head (hit_is_head),
    .hit_data    (hit_data),
    .head_tag    (head_tag),
    .head_data   (head_data),
    .full        (full),
    .empty       (buf_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      resp_reg  <= resp_next;
      rdata_reg <= rdata_next;
    end
  end

  // Registered responses (hit, write accept) go out during WAIT, so the
  // cache has dropped its request by the time IDLE looks at it again.
  always_comb begin
    state_next = state_reg;
    resp_next  = 1'b0;
    rdata_next = rdata_reg;
    push_en    = 1'b0;
    ovr_en     = 1'b0;
    pop_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cache.read) begin
          if (hit) begin
            rdata_next = hit_data;
            resp_next  = 1'b1;
            state_next = WAIT;
          end else begin
            state_next = FWD_READ;
          end
        end else if (cache.write) begin
          // The head may be on its way out, so it is never coalesced into.
          if (hit && !hit_is_head) begin
            ovr_en     = 1'b1;
            resp_next  = 1'b1;
            state_next = WAIT;
          end else if (!full) begin
            push_en    = 1'b1;
            resp_next  = 1'b1;
            state_next = WAIT;
          end else begin
            state_next = DRAIN;
          end
        end else if (!buf_empty) begin
          state_next = DRAIN;
        end
      end
      FWD_READ: if (arb.resp) state_next = WAIT;
      DRAIN: begin
        if (arb.resp) begin
          pop_en     = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    arb.read    = 1'b0;
    arb.write   = 1'b0;
    arb.address = '0;
    arb.wdata   = '0;
    cache.rdata = rdata_reg;
    cache.resp  = resp_reg;
    case (state_reg)
      FWD_READ: begin
        arb.read    = 1'b1;
        arb.address = cache.address;
        cache.rdata = arb.rdata;
        cache.resp  = arb.resp;
      end
      DRAIN: begin
        arb.write   = 1'b1;
        arb.address = {head_tag, {OFFSET_BITS{1'b0}}};
        arb.wdata   = head_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_write_buffer.sv
// Self-checking bench for data_write_buffer (DEPTH=2).
module tb_data_write_buffer;
  import data_write_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic buf_empty;

  data_write_buffer_if cache_if ();
  data_write_buffer_if arb_if ();

  data_write_buffer #(.DEPTH(2), .OFFSET_BITS(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cache     (cache_if),
    .arb       (arb_if),
    .buf_empty (buf_empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int resp_count = 0;
  int arb_lat = 2;
  int arb_resp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit        wr;
    rv32i_word addr;
    rv32i_line data;
  } arb_txn_t;

  typedef struct {
    bit        wr;
    rv32i_word addr;
    rv32i_line data;
    rv32i_line exp_rdata;
    int        exp_lat;
  } vec_t;

  arb_txn_t arb_exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic rv32i_line mk_line(input logic [31:0] seed);
    rv32i_line l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed + 32'(i) * 32'h0101_0101;
    return l;
  endfunction

  function automatic rv32i_line mem_line(input rv32i_word addr);
    return mk_line(addr ^ 32'h5A5A_0000);
  endfunction

  function automatic arb_txn_t txn(input bit wr, input rv32i_word addr, input rv32i_line data);
    arb_txn_t t;
    t.wr = wr; t.addr = addr; t.data = data;
    return t;
  endfunction

  // Arbiter model: checks each new request against the scoreboard, stalls
  // arb_lat cycles, then pulses resp for one cycle.
  initial begin
    arb_if.rdata = '0;
    arb_if.resp  = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (reset_n && (arb_if.read || arb_if.write)) begin
        arb_txn_t got, want;
        bit aborted;
        aborted  = 1'b0;
        got.wr   = arb_if.write;
        got.addr = arb_if.address;
        got.data = arb_if.write ? arb_if.wdata : '0;
        $display("arb %s addr=%h", got.wr ? "write" : "read ", got.addr);
        if (arb_exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL arb_unexpected: got wr=%0d addr=%h, want no request", got.wr, got.addr);
        end else begin
          want = arb_exp_q.pop_front();
          check("arb_kind", 256'(got.wr), 256'(want.wr));
          check("arb_addr", 256'(got.addr), 256'(want.addr));
          if (want.wr) check("arb_wdata", got.data, want.data);
        end
        for (int i = 0; i < arb_lat; i++) begin
          @(posedge clk); #2;
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          check("arb_hold", 256'({arb_if.write, arb_if.read, arb_if.address}),
                256'({got.wr, !got.wr, got.addr}));
          arb_if.rdata = got.wr ? '0 : mem_line(got.addr);
          arb_if.resp  = 1'b1;
          arb_resp_cyc = cyc;
          @(posedge clk); #2;
          arb_if.resp  = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cache_if.resp) resp_count++;
    check("arb_overlap", 256'(arb_if.read & arb_if.write), 256'(0));
  end

  // Latency counts the request cycle as cycle 1.
  task automatic cache_op(input bit wr, input rv32i_word addr, input rv32i_line wdata,
                          input rv32i_line exp_rdata, input int exp_lat, input string name,
                          output int resp_cyc);
    int lat;
    bit got;
    @(negedge clk);
    cache_if.address = addr;
    cache_if.wdata   = wr ? wdata : '0;
    cache_if.read    = !wr;
    cache_if.write   = wr;
    lat = 1;
    got = 1'b0;
    resp_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (cache_if.resp) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no cache_resp, want one within 300 cycles", name);
    end else begin
      resp_cyc = cyc;
      if (!wr) check({name, "_rdata"}, cache_if.rdata, exp_rdata);
      if (exp_lat > 0) check({name, "_lat"}, 256'(lat), 256'(exp_lat));
    end
    $display("cache %s addr=%h lat=%0d rdata=%h", wr ? "write" : "read ", addr, lat, cache_if.rdata);
    @(posedge clk); #1;
    cache_if.read  = 1'b0;
    cache_if.write = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (buf_empty && !arb_if.write && !arb_if.read) begin
        done = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_drain_timeout: got buffer still busy, want drained", name);
    end
    check({name, "_buf_empty"}, 256'(buf_empty), 256'(1));
    check({name, "_arb_queue"}, 256'(arb_exp_q.size()), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    rv32i_line la, lb, lc, ld, le, lf, lg, lh;
    int rc, base;

    la = mk_line(32'hA000_0001); lb = mk_line(32'hB000_0002);
    lc = mk_line(32'hC000_0003); ld = mk_line(32'hD000_0004);
    le = mk_line(32'hE000_0005); lf = mk_line(32'hF000_0006);
    lg = mk_line(32'h1234_0007); lh = mk_line(32'h8765_0008);

    cache_if.address = '0; cache_if.read = 1'b0;
    cache_if.write = 1'b0; cache_if.wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cache_resp", 256'(cache_if.resp), 256'(0));
    check("rst_cache_rdata", cache_if.rdata, '0);
    check("rst_arb_read", 256'(arb_if.read), 256'(0));
    check("rst_arb_write", 256'(arb_if.write), 256'(0));
    check("rst_arb_address", 256'(arb_if.address), 256'(0));
    check("rst_arb_wdata", arb_if.wdata, '0);
    check("rst_buf_empty", 256'(buf_empty), 256'(1));
    reset_n = 1'b1;

    // Eviction then miss, forwarding, read hit on an older entry.
    // The write after the forwarded read sees one extra WAIT cycle (lat 3).
    // Miss latency: request cycle + 2 stall cycles + resp cycle = 4.
    arb_lat = 2;
    vecs[0] = '{1'b1, 32'h0000_1000, la, '0, 2};
    vecs[1] = '{1'b0, 32'h0000_2000, '0, mem_line(32'h0000_2000), 4};
    vecs[2] = '{1'b1, 32'h0000_3000, lb, '0, 3};
    vecs[3] = '{1'b0, 32'h0000_3000, '0, lb, 2};
    vecs[4] = '{1'b0, 32'h0000_1000, '0, la, 2};
    arb_exp_q.push_back(txn(1'b0, 32'h0000_2000, '0));
    arb_exp_q.push_back(txn(1'b1, 32'h0000_1000, la));
    arb_exp_q.push_back(txn(1'b1, 32'h0000_3000, lb));
    base = resp_count;
    for (int i = 0; i < 5; i++)
      cache_op(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rdata, vecs[i].exp_lat,
               $sformatf("vec%0d", i), rc);
    wait_drained("s1");
    check("s1_resp_count", 256'(resp_count - base), 256'(5));

    // Coalesce into a non-head entry, then a write into the full buffer.
    arb_lat = 3;
    arb_exp_q.push_back(txn(1'b1, 32'h0000_4000, lc));
    arb_exp_q.push_back(txn(1'b1, 32'h0000_5000, le));
    arb_exp_q.push_back(txn(1'b1, 32'h0000_6000, lf));
    base = resp_count;
    cache_op(1'b1, 32'h0000_4000, lc, '0, 2, "wr_c", rc);
    cache_op(1'b1, 32'h0000_5000, ld, '0, 2, "wr_d", rc);
    cache_op(1'b1, 32'h0000_5000, le, '0, 2, "coalesce_e", rc);
    cache_op(1'b1, 32'h0000_6000, lf, '0, 0, "full_f", rc);
    // Pop on the edge after arb_resp, push on the next, resp right after.
    check("full_stall_resp_cyc", 256'(rc), 256'(arb_resp_cyc + 2));
    wait_drained("s2");
    check("s2_resp_count", 256'(resp_count - base), 256'(4));

    // Read arriving mid-drain waits for the drain to complete.
    arb_lat = 5;
    arb_exp_q.push_back(txn(1'b1, 32'h0000_6000, lg));
    arb_exp_q.push_back(txn(1'b0, 32'h0000_7000, '0));
    base = resp_count;
    cache_op(1'b1, 32'h0000_6000, lg, '0, 2, "wr_g", rc);
    repeat (2) @(negedge clk);
    check("s3_drain_started", 256'(arb_if.write), 256'(1));
    cache_op(1'b0, 32'h0000_7000, '0, mem_line(32'h0000_7000), 0, "rd_mid_drain", rc);
    wait_drained("s3");
    check("s3_resp_count", 256'(resp_count - base), 256'(2));

    // Asynchronous reset in the middle of a drain.
    arb_lat = 40;
    arb_exp_q.push_back(txn(1'b1, 32'h0000_8000, lh));
    cache_op(1'b1, 32'h0000_8000, lh, '0, 2, "wr_h", rc);
    repeat (2) @(negedge clk);
    check("s4_drain_started", 256'(arb_if.write), 256'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("s4_rst_arb_write", 256'(arb_if.write), 256'(0));
    check("s4_rst_buf_empty", 256'(buf_empty), 256'(1));
    check("s4_rst_arb_address", 256'(arb_if.address), 256'(0));
    check("s4_rst_arb_wdata", arb_if.wdata, '0);
    base = resp_count;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("s4_no_resp", 256'(resp_count - base), 256'(0));
    check("s4_arb_idle", 256'({arb_if.read, arb_if.write}), 256'(0));
    check("s4_buf_empty", 256'(buf_empty), 256'(1));
    check("s4_arb_queue", 256'(arb_exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
